ahb_gpio_ctrl: RTL and testbench
================================

Name: ahb_gpio_ctrl

Overview:
- Parametrised AHB-Lite GPIO peripheral: N pins, per-pin direction, atomic set/clear of output bits, synchronised input sampling, and per-pin edge-detect interrupts.
- Sits on the multicycle AHB bus as a slave.
- Drives pin_out/pin_oe to the chip-top tristate pads and reads raw pad values on pin_in.

Parameters:
- N, 32, pin count (1..32); register bits [31:N] read 0 and ignore writes.
- SYNC_STAGES, 2, input synchroniser depth (2..4).

Ports:
- HCLK  input  1  clock; all state updates on rising edge.
- HRESET  input  1  asynchronous, active-high reset.
- HSEL  input  1  slave select.
- HADDR  input  5  byte address; bits [4:2] select the register, bits [1:0] ignored.
- HTRANS  input  2  only HTRANS[1] is used (NONSEQ/SEQ = valid).
- HWRITE  input  1  1 = write.
- HREADY  input  1  bus ready; an address phase is accepted only when it is 1.
- HWDATA  input  32  write data, valid in the data phase.
- HRDATA  output  32  read data, valid in the data phase.
- HREADYOUT  output  1  tied 1 (zero wait states).
- pin_out  output  N  output values.
- pin_oe  output  N  1 = drive the pad.
- pin_in  input  N  raw pad values (asynchronous).
- irq  output  1  level interrupt, equal to OR over (STATUS & IEN).

Behaviour:
- Register map (word offsets):
  - 0x00 OUT (RW)
  - 0x04 DIR (RW)
  - 0x08 IN (RO, synchronised value)
  - 0x0C IEN (RW)
  - 0x10 EDGE (RW; 1 = rising, 0 = falling)
  - 0x14 STATUS (read; write-1-to-clear)
  - 0x18 OUTSET (WO; OUT |= wdata)
  - 0x1C OUTCLR (WO; OUT &= ~wdata)
  - Reads of write-only registers return 0. HSIZE is not decoded; all accesses are treated as 32-bit.
- Address phase: when HSEL & HTRANS[1] & HREADY, register addr_q <= HADDR[4:2], wr_q <= HWRITE, act_q <= 1. Otherwise act_q <= 0.
- Write: performed on the HCLK edge that ends the data phase, using HWDATA. pin_out/pin_oe change 1 cycle after that data phase.
- Read: HRDATA is combinational from addr_q during the data phase, and is 0 when act_q = 0. A read of OUT immediately after a write to OUT returns the new value.
- Back-to-back transfers are supported at 1 per cycle.
- pin_out = OUT[N-1:0]; pin_oe = DIR[N-1:0].
- Synchroniser:
  - pin_in feeds a SYNC_STAGES-deep flop chain; the last stage is s.
  - prev <= s every cycle.
  - IN reads s.
  - A pin change stable before edge 1 appears on s after edge SYNC_STAGES.
- Edge detect:
  - rise = s & ~prev; fall = ~s & prev.
  - ev = (EDGE & rise) | (~EDGE & fall).
  - STATUS <= (STATUS & ~w1c) | ev. On a simultaneous W1C and new event for the same bit, the set wins.
  - STATUS records events regardless of IEN.
  - irq rises in the same cycle STATUS is set, i.e. after edge SYNC_STAGES+1.
- Output pins are also sampled: with DIR = 1, IN reflects the pad and edges still fire.
- Warm-up FSM, states ARM -> RUN:
  - After reset a counter loads SYNC_STAGES+1 and decrements each cycle.
  - While in ARM, ev is forced to 0. This prevents pins already high at reset from raising spurious edges.
  - At count 0 the FSM moves to RUN and stays there until reset.
- Reset (asynchronous, any time including mid-transfer):
  - OUT, DIR, IEN, EDGE, STATUS, sync chain, prev, addr_q, wr_q, act_q all go to 0. The FSM returns to ARM.
  - Outputs: pin_out = 0, pin_oe = 0, irq = 0, HRDATA = 0, HREADYOUT = 1.
  - A data phase in flight at reset is dropped; no write occurs.
- Idle or unselected cycles (HTRANS[1] = 0 or HSEL = 0): no register change.

Test Plan:
- Reset then write DIR = 0x0000_00FF, OUT = 0xA5 -> pin_oe = 0xFF and pin_out = 0xA5 one cycle after the data phase; read OUT returns 0x0000_00A5.
- OUT = 0xF0, then write OUTSET = 0x0F, then write OUTCLR = 0x81, back-to-back -> OUT = 0x7E; reading OUTSET returns 0.
- Drive pin_in[3] 0->1 with IEN = 0x8 and EDGE = 0x8 -> IN[3] = 1 after 2 edges; STATUS = 0x8 and irq = 1 after edge 3. Write STATUS = 0x8 -> irq = 0 next cycle.
- EDGE[5] = 0 and pin_in[5] 1->0 with IEN = 0 -> STATUS[5] = 1 and irq stays 0. Then set IEN = 0x20 -> irq = 1.
- Hold pin_in = 0xFFFF_FFFF through reset release -> STATUS stays 0 for at least 10 cycles; IN = 0xFFFF_FFFF.
- N = 8 build: write OUT = 0xFFFF_FFFF -> read returns 0x0000_00FF. Assert HRESET mid write data phase -> OUT = 0 and pin_oe = 0 immediately.

Source files
------------

// File: rtl/ahb_gpio_ctrl.sv
// AHB-Lite GPIO slave: per-pin direction, atomic set/clear of outputs,
// synchronised inputs and per-pin edge-detect interrupts with a reset warm-up.
module ahb_gpio_ctrl #(
  parameter int N           = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic         HCLK,
  input  logic         HRESET,
  input  logic         HSEL,
  input  logic [4:0]   HADDR,
  input  logic [1:0]   HTRANS,
  input  logic         HWRITE,
  input  logic         HREADY,
  input  logic [31:0]  HWDATA,
  output logic [31:0]  HRDATA,
  output logic         HREADYOUT,
  output logic [N-1:0] pin_out,
  output logic [N-1:0] pin_oe,
  input  logic [N-1:0] pin_in,
  output logic         irq
);

  localparam logic [2:0] A_OUT    = 3'd0;
  localparam logic [2:0] A_DIR    = 3'd1;
  localparam logic [2:0] A_IN     = 3'd2;
  localparam logic [2:0] A_IEN    = 3'd3;
  localparam logic [2:0] A_EDGE   = 3'd4;
  localparam logic [2:0] A_STATUS = 3'd5;
  localparam logic [2:0] A_OUTSET = 3'd6;
  localparam logic [2:0] A_OUTCLR = 3'd7;

  localparam logic [2:0] WARM_CNT = 3'(SYNC_STAGES + 1);

  typedef enum logic {ARM, RUN} warm_state_e;

  logic [2:0]   r_addr_q;
  logic         r_wr_q;
  logic         r_act_q;
  logic [N-1:0] r_out;
  logic [N-1:0] r_dir;
  logic [N-1:0] r_ien;
  logic [N-1:0] r_edge;
  logic [N-1:0] r_status;
  logic [N-1:0] r_sync [SYNC_STAGES];
  logic [N-1:0] r_prev;
  warm_state_e  r_state;
  logic [2:0]   r_cnt;

  logic         w_wr_en;
  logic [N-1:0] w_wdata;
  logic [N-1:0] w_w1c;
  logic [N-1:0] w_s;
  logic [N-1:0] w_ev;
  logic [N-1:0] w_rdata_n;
  logic [31:0]  w_rdata;
  logic         w_unused;

  // Address bits [1:0], HTRANS[0] and HWDATA[31:N] carry no meaning here.
  assign w_unused = ^{HADDR[1:0], HTRANS[0], HWDATA};

  assign w_wr_en = r_act_q & r_wr_q;
  assign w_wdata = HWDATA[N-1:0];
  assign w_w1c   = (w_wr_en && r_addr_q == A_STATUS) ? w_wdata : '0;
  assign w_s     = r_sync[SYNC_STAGES-1];
  assign w_ev    = (r_state == RUN)
                 ? ((r_edge & w_s & ~r_prev) | (~r_edge & ~w_s & r_prev))
                 : '0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_addr_q <= '0;
      r_wr_q   <= 1'b0;
      r_act_q  <= 1'b0;
    end else if (HSEL && HTRANS[1] && HREADY) begin
      r_addr_q <= HADDR[4:2];
      r_wr_q   <= HWRITE;
      r_act_q  <= 1'b1;
    end else begin
      r_act_q  <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_out    <= '0;
      r_dir    <= '0;
      r_ien    <= '0;
      r_edge   <= '0;
      r_status <= '0;
    end else begin
      if (w_wr_en) begin
        case (r_addr_q)
          A_OUT:    r_out  <= w_wdata;
          A_DIR:    r_dir  <= w_wdata;
          A_IEN:    r_ien  <= w_wdata;
          A_EDGE:   r_edge <= w_wdata;
          A_OUTSET: r_out  <= r_out | w_wdata;
          A_OUTCLR: r_out  <= r_out & ~w_wdata;
          default:  ;
        endcase
      end
      // A new event outranks a simultaneous write-1-to-clear.
      r_status <= (r_status & ~w_w1c) | w_ev;
    end
  end

  // NOTE: the synchroniser array is reset explicitly; it is a flop chain, not
  // a RAM, and the warm-up relies on it starting from a known 0.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= pin_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_s;
    end
  end

  // Edge events stay masked until the synchroniser and prev hold real pad values.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= ARM;
      r_cnt   <= WARM_CNT;
    end else if (r_state == ARM) begin
      if (r_cnt == 3'd0) r_state <= RUN;
      else               r_cnt   <= r_cnt - 3'd1;
    end
  end

  // NOTE: defaults assigned first so no path through the case infers a latch.
  always_comb begin
    w_rdata_n = '0;
    case (r_addr_q)
      A_OUT:    w_rdata_n = r_out;
      A_DIR:    w_rdata_n = r_dir;
      A_IN:     w_rdata_n = w_s;
      A_IEN:    w_rdata_n = r_ien;
      A_EDGE:   w_rdata_n = r_edge;
      A_STATUS: w_rdata_n = r_status;
      default:  w_rdata_n = '0;
    endcase
    w_rdata = '0;
    w_rdata[N-1:0] = w_rdata_n;
  end

  assign HRDATA    = r_act_q ? w_rdata : 32'd0;
  assign HREADYOUT = 1'b1;
  assign pin_out   = r_out;
  assign pin_oe    = r_dir;
  assign irq       = |(r_status & r_ien);

endmodule

// File: tb/tb_ahb_gpio_ctrl.sv
// Directed bench for ahb_gpio_ctrl: a 32-pin and an 8-pin instance share one bus.
module tb_ahb_gpio_ctrl;

  localparam logic [4:0] A_OUT    = 5'h00;
  localparam logic [4:0] A_DIR    = 5'h04;
  localparam logic [4:0] A_IN     = 5'h08;
  localparam logic [4:0] A_IEN    = 5'h0C;
  localparam logic [4:0] A_EDGE   = 5'h10;
  localparam logic [4:0] A_STATUS = 5'h14;
  localparam logic [4:0] A_OUTSET = 5'h18;
  localparam logic [4:0] A_OUTCLR = 5'h1C;

  logic        HCLK, HRESET, HSEL, HWRITE, HREADY;
  logic [4:0]  HADDR;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA, HRDATA, hrdata8;
  logic        HREADYOUT, hreadyout8, irq, irq8;
  logic [31:0] pin_out, pin_oe, pin_in;
  logic [7:0]  pin_out8, pin_oe8, pin_in8;

  int n_checks = 0;
  int n_bad    = 0;
  logic [31:0] d, d8;

  assign pin_in8 = pin_in[7:0];

  ahb_gpio_ctrl #(.N(32), .SYNC_STAGES(2)) u_dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .pin_out(pin_out), .pin_oe(pin_oe), .pin_in(pin_in),
    .irq(irq)
  );

  ahb_gpio_ctrl #(.N(8), .SYNC_STAGES(2)) u_dut8 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(hrdata8),
    .HREADYOUT(hreadyout8), .pin_out(pin_out8), .pin_oe(pin_oe8), .pin_in(pin_in8),
    .irq(irq8)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Drive one bus slot at a falling edge and advance to the next falling edge.
  // wd is the write data for the previous slot's address phase.
  task automatic step(input logic v, input logic w, input logic [4:0] a, input logic [31:0] wd);
    HSEL   = v;
    HTRANS = v ? 2'b10 : 2'b00;
    HWRITE = w;
    HADDR  = a;
    HWDATA = wd;
    @(negedge HCLK);
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] wd);
    step(1'b1, 1'b1, a, 32'd0);
    step(1'b0, 1'b0, 5'd0, wd);
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] rd, output logic [31:0] rd8);
    step(1'b1, 1'b0, a, 32'd0);
    rd  = HRDATA;
    rd8 = hrdata8;
    step(1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = '0; HWRITE = 1'b0;
    HREADY = 1'b1; HWDATA = '0; pin_in = '0;
    @(negedge HCLK);
    @(negedge HCLK);
    check("rst_pin_out", pin_out, 32'd0);
    check("rst_pin_oe", pin_oe, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_hrdata", HRDATA, 32'd0);
    check("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    HRESET = 1'b0;
    idle(5);

    // DIR and OUT back to back; OUT reaches the pin only after its data phase.
    step(1'b1, 1'b1, A_DIR, 32'd0);
    step(1'b1, 1'b1, A_OUT, 32'h0000_00FF);
    check("dir_pin_oe", pin_oe, 32'h0000_00FF);
    check("out_before", pin_out, 32'd0);
    step(1'b0, 1'b0, 5'd0, 32'h0000_00A5);
    check("out_after", pin_out, 32'h0000_00A5);
    bus_read(A_OUT, d, d8);
    check("rd_out", d, 32'h0000_00A5);

    // Read of OUT directly behind a write to OUT sees the new value.
    step(1'b1, 1'b1, A_OUT, 32'd0);
    step(1'b1, 1'b0, A_OUT, 32'h0000_005A);
    check("rd_after_wr", HRDATA, 32'h0000_005A);
    step(1'b0, 1'b0, 5'd0, 32'd0);

    // OUT=F0, OUTSET 0F, OUTCLR 81 at one transfer per cycle -> 7E.
    step(1'b1, 1'b1, A_OUT, 32'd0);
    step(1'b1, 1'b1, A_OUTSET, 32'h0000_00F0);
    step(1'b1, 1'b1, A_OUTCLR, 32'h0000_000F);
    step(1'b1, 1'b0, A_OUT, 32'h0000_0081);
    check("setclr_rd", HRDATA, 32'h0000_007E);
    check("setclr_pin", pin_out, 32'h0000_007E);
    step(1'b1, 1'b0, A_OUTSET, 32'd0);
    check("rd_outset", HRDATA, 32'd0);
    step(1'b1, 1'b0, A_OUTCLR, 32'd0);
    check("rd_outclr", HRDATA, 32'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0);

    // Rising edge on pin 3: IN after 2 edges, STATUS/irq after 3.
    bus_write(A_IEN, 32'h0000_0008);
    bus_write(A_EDGE, 32'h0000_0008);
    pin_in[3] = 1'b1;
    step(1'b1, 1'b0, A_IN, 32'd0);
    check("in_edge1", HRDATA, 32'd0);
    step(1'b1, 1'b0, A_IN, 32'd0);
    check("in_edge2", HRDATA, 32'h0000_0008);
    check("irq_edge2", {31'd0, irq}, 32'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0);
    check("irq_edge3", {31'd0, irq}, 32'd1);
    step(1'b1, 1'b1, A_STATUS, 32'd0);
    check("irq_held", {31'd0, irq}, 32'd1);
    step(1'b0, 1'b0, 5'd0, 32'h0000_0008);
    check("irq_w1c", {31'd0, irq}, 32'd0);
    bus_read(A_STATUS, d, d8);
    check("status_w1c", d, 32'd0);

    // Falling edge on pin 5 with its interrupt disabled.
    bus_write(A_IEN, 32'd0);
    pin_in[5] = 1'b1;
    idle(4);
    bus_read(A_STATUS, d, d8);
    check("rise5_ignored", d, 32'd0);
    pin_in[5] = 1'b0;
    idle(4);
    bus_read(A_STATUS, d, d8);
    check("fall5_status", d, 32'h0000_0020);
    check("fall5_irq_off", {31'd0, irq}, 32'd0);
    bus_write(A_IEN, 32'h0000_0020);
    check("fall5_irq_on", {31'd0, irq}, 32'd1);

    // Pins high through reset, rising edges enabled immediately: no events.
    HRESET = 1'b1;
    pin_in = 32'hFFFF_FFFF;
    idle(3);
    check("rst2_status_irq", {31'd0, irq}, 32'd0);
    check("rst2_pin_out", pin_out, 32'd0);
    HRESET = 1'b0;
    bus_write(A_EDGE, 32'hFFFF_FFFF);
    for (int i = 0; i < 6; i++) begin
      bus_read(A_STATUS, d, d8);
      check("warm_status", d, 32'd0);
    end
    check("warm_status8", d8, 32'd0);
    bus_read(A_IN, d, d8);
    check("warm_in", d, 32'hFFFF_FFFF);
    check("warm_in8", d8, 32'h0000_00FF);

    // Narrow instance: bits above N read 0.
    bus_write(A_OUT, 32'hFFFF_FFFF);
    bus_read(A_OUT, d, d8);
    check("n32_out", d, 32'hFFFF_FFFF);
    check("n8_out", d8, 32'h0000_00FF);
    bus_write(A_DIR, 32'hFFFF_FFFF);
    check("n8_pin_oe", {24'd0, pin_oe8}, 32'h0000_00FF);

    // Reset asserted in the middle of a write data phase.
    step(1'b1, 1'b1, A_OUT, 32'd0);
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h0000_0033;
    #2 HRESET = 1'b1;
    #1;
    check("midrst_pin_out", pin_out, 32'd0);
    check("midrst_pin_oe", pin_oe, 32'd0);
    check("midrst_pin_oe8", {24'd0, pin_oe8}, 32'd0);
    check("midrst_hrdata", HRDATA, 32'd0);
    @(negedge HCLK);
    HRESET = 1'b0;
    idle(2);
    bus_read(A_OUT, d, d8);
    check("midrst_dropped", d, 32'd0);
    check("midrst_dropped8", d8, 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
